keypoint_queue: RTL and testbench
=================================

# keypoint_queue

- Parametrised, order-preserving keypoint holding queue between the orientation stage and the BRIEF descriptor stage.
- Holds one packed keypoint record per detected corner until the descriptor window for that corner has streamed in, then presents it to the descriptor stage.
- Successor to the fixed 60-entry shift buffer: adds a generic depth and record width, plus explicit full/empty/count status, a synchronous clear, and drop reporting.
- Optional replacement mode: when the queue is full, a stronger corner evicts the weakest one.

## Interface
Parameters:
- DEPTH, 60, number of entries (≥2)
- DATA_W, 62, packed record width {sin[12], cos[12], x[10], y[10], score[8], depth[10]}
- SCORE_LSB, 10, bit position of the 8-bit score field inside the record
- CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_clear  in  1  synchronous flush; empties the queue
- i_push  in  1  write i_data at tail
- i_pop  in  1  consume head entry (hit)
- i_data  in  DATA_W  incoming keypoint record
- o_data  out  DATA_W  head (oldest) record; all zeros when empty
- o_valid  out  1  head is valid (count ≠ 0)
- o_count  out  CNT_W  occupancy
- o_full  out  1  count == DEPTH
- o_drop  out  1  one-cycle pulse: a push was discarded
- o_underflow  out  1  one-cycle pulse: pop issued while empty

## Operation
- Storage: entry array e[0..DEPTH-1], compacted; e[0] is head; entries ≥ count are held at zero.
- Reset (i_rst high, async): all entries 0, count 0, o_drop 0, o_underflow 0. Therefore o_valid=0, o_full=0, o_data=0.
- Per-cycle priority: i_clear > push/pop.
- i_clear: count←0, all entries←0; any push/pop in the same cycle is ignored.
- Pop only, count>0: shift e[i]←e[i+1]; e[DEPTH-1]←0; count−1.
- Pop only, count==0: no state change; o_underflow=1.
- Push only, not full: e[count]←i_data; count+1.
- Push and pop, count>0: shift, then e[count-1]←i_data; count unchanged.
- Push and pop, count==0: record written to e[0]; count←1; o_underflow=1.
  - The pop is not applied to the newly pushed record.
- Push only, full: behaviour depends on KEYBUF_SCORE_REPLACE_EN (see Configuration).
- Score compare: unsigned 8-bit, i_data[SCORE_LSB+:8] against e[k][SCORE_LSB+:8].

## Timing
- All outputs are registered or decoded directly from registers; there is no combinational path from any input to any output.
- Push at edge t into an empty queue → o_valid=1 and o_data=record after edge t.
  - Latency is 1 cycle.
- A pop at edge t → the next record is on o_data after edge t.
- o_drop and o_underflow are asserted in the cycle after the offending edge, for exactly one cycle.
- Back-to-back push+pop every cycle is supported with no bubbles.
- Reset asserted mid-operation clears everything immediately; the first push after reset release behaves as a push into an empty queue.

## Configuration
Macro: KEYBUF_SCORE_REPLACE_EN.
- Defined, push while full without pop:
  - Find the minimum score among the DEPTH entries; ties go to the lowest index (oldest).
  - If the incoming score is strictly greater, overwrite that entry in place. Count and order of the other entries are unchanged, and o_drop=0.
  - Otherwise the incoming record is discarded and o_drop=1.
- Undefined, push while full without pop: the incoming record is always discarded and o_drop=1.
  - No comparator logic is generated.

## Structure
- Shared package keybuf_pkg holds:
  - field width constants: SIN_W=12, COS_W=12, COOR_W=10, SCORE_W=8, DEPTH_W=10
  - KP_W=62 and the record field offsets
  - default DEPTH
- Sub-module keybuf_min_finder:
  - combinational argmin tree over DEPTH scores
  - outputs min score and index, with lowest-index tie-break
  - instantiated only under KEYBUF_SCORE_REPLACE_EN

## Test plan
- Reset then idle:
  - o_valid=0, o_count=0, o_data=0.
  - Push records A, B, C (scores 10, 20, 30), then pop ×3 → o_data shows A, B, C in order, then 0; o_count goes 3, 2, 1, 0.
- Fill DEPTH=4 with scores 5, 9, 3, 7, then push score 4:
  - macro on → entry 2 replaced, o_drop=0, order is 5, 9, 4, 7.
  - macro off → o_drop pulse, contents unchanged.
- Full DEPTH=4, simultaneous push+pop of X → head removed, X at tail, o_full stays 1, no o_drop.
- Pop on empty → o_underflow one-cycle pulse, count stays 0.
  - Push+pop on empty → count=1, head=record, o_underflow pulse.
- Queue at count 3, i_clear together with i_push → count=0, o_valid=0, push ignored.
- Assert i_rst mid-stream with count 2 → outputs zero immediately.
  - After release, push D → o_data=D after one cycle.

Source files
------------

// File: rtl/keybuf_pkg.sv
// Shared keypoint record layout and default queue depth for the keypoint buffer.
// Record, MSB first: {sin, cos, x, y, score, depth}.
package keybuf_pkg;
  localparam int SIN_W   = 12;
  localparam int COS_W   = 12;
  localparam int COOR_W  = 10;
  localparam int SCORE_W = 8;
  localparam int DEPTH_W = 10;

  localparam int KP_W = SIN_W + COS_W + 2 * COOR_W + SCORE_W + DEPTH_W;

  localparam int DEPTH_OFF = 0;
  localparam int SCORE_OFF = DEPTH_OFF + DEPTH_W;
  localparam int Y_OFF     = SCORE_OFF + SCORE_W;
  localparam int X_OFF     = Y_OFF + COOR_W;
  localparam int COS_OFF   = X_OFF + COOR_W;
  localparam int SIN_OFF   = COS_OFF + COS_W;

  localparam int KB_DEPTH = 60;
endpackage

// File: rtl/keybuf_min_finder.sv
// Combinational argmin over DEPTH packed scores; ties resolve to the lowest index.
// Only instantiated when KEYBUF_SCORE_REPLACE_EN is defined.
module keybuf_min_finder
  import keybuf_pkg::*;
#(
  parameter int DEPTH = KB_DEPTH
) (
  input  logic [DEPTH*SCORE_W-1:0]   scores_i,
  output logic [SCORE_W-1:0]         min_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o
);
  localparam int IDX_W = $clog2(DEPTH);

  // Strict less-than keeps the earliest (oldest) entry on equal scores.
  always_comb begin
    min_o = scores_i[SCORE_W-1:0];
    idx_o = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (scores_i[i*SCORE_W +: SCORE_W] < min_o) begin
        min_o = scores_i[i*SCORE_W +: SCORE_W];
        idx_o = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/keypoint_queue.sv
// Order-preserving keypoint holding queue (head at e[0]); 1-cycle push-to-head latency.
// Optional KEYBUF_SCORE_REPLACE_EN: a push into a full queue evicts the weakest entry if stronger.
module keypoint_queue
  import keybuf_pkg::*;
#(
  parameter int DEPTH     = KB_DEPTH,
  parameter int DATA_W    = KP_W,
  parameter int SCORE_LSB = SCORE_OFF,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_drop,
  output logic              o_underflow
);
  logic [DATA_W-1:0] e_q [DEPTH];
  logic [DATA_W-1:0] e_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drop_q, drop_d;
  logic              underflow_q, underflow_d;
  logic              full;

  assign full = (count_q == CNT_W'(DEPTH));

`ifdef KEYBUF_SCORE_REPLACE_EN
  localparam int IDX_W = $clog2(DEPTH);
  logic [DEPTH*SCORE_W-1:0] scores;
  logic [SCORE_W-1:0]       min_score;
  logic [IDX_W-1:0]         min_idx;

  always_comb begin
    scores = '0;
    for (int i = 0; i < DEPTH; i++) scores[i*SCORE_W +: SCORE_W] = e_q[i][SCORE_LSB +: SCORE_W];
  end

  keybuf_min_finder #(.DEPTH(DEPTH)) u_min (
    .scores_i (scores),
    .min_o    (min_score),
    .idx_o    (min_idx)
  );
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) e_d[i] = e_q[i];
    count_d     = count_q;
    drop_d      = 1'b0;
    underflow_d = 1'b0;

    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) e_d[i] = '0;
      count_d = '0;
    end else if (i_pop && count_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) e_d[i] = e_q[i+1];
      e_d[DEPTH-1] = '0;
      if (i_push) begin
        // Write lands at the slot that was the tail before the shift, so count is unchanged.
        for (int i = 0; i < DEPTH; i++) if (CNT_W'(i + 1) == count_q) e_d[i] = i_data;
      end else begin
        count_d = count_q - 1'b1;
      end
    end else if (i_pop) begin
      underflow_d = 1'b1;
      if (i_push) begin
        e_d[0]  = i_data;
        count_d = CNT_W'(1);
      end
    end else if (i_push && !full) begin
      for (int i = 0; i < DEPTH; i++) if (CNT_W'(i) == count_q) e_d[i] = i_data;
      count_d = count_q + 1'b1;
    end else if (i_push) begin
`ifdef KEYBUF_SCORE_REPLACE_EN
      if (i_data[SCORE_LSB +: SCORE_W] > min_score) begin
        for (int i = 0; i < DEPTH; i++) if (IDX_W'(i) == min_idx) e_d[i] = i_data;
      end else begin
        drop_d = 1'b1;
      end
`else
      drop_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= e_d[i];
      count_q     <= count_d;
      drop_q      <= drop_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_data      = e_q[0];
  assign o_valid     = (count_q != '0);
  assign o_count     = count_q;
  assign o_full      = full;
  assign o_drop      = drop_q;
  assign o_underflow = underflow_q;
endmodule

// File: tb/tb_keypoint_queue.sv
// Directed bench for keypoint_queue at DEPTH=4; expectations follow KEYBUF_SCORE_REPLACE_EN.
module tb_keypoint_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 62;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              drop;
  logic              uflow;

  int checks = 0;
  int failures = 0;

  keypoint_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SCORE_LSB(10), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_push      (push),
    .i_pop       (pop),
    .i_data      (din),
    .o_data      (dout),
    .o_valid     (valid),
    .o_count     (count),
    .o_full      (full),
    .o_drop      (drop),
    .o_underflow (uflow)
  );

  always #5 clk = ~clk;

  // Tag goes in the x field so records with equal scores stay distinguishable.
  function automatic logic [DATA_W-1:0] mk(input logic [7:0] s, input logic [9:0] tag);
    return {12'd0, 12'd0, tag, 10'd0, s, 10'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic q, input logic c, input logic [DATA_W-1:0] d);
    push = p; pop = q; clear = c; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; din = '0;
  endtask

  initial begin
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data",  64'(dout),  64'd0);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_drop",  64'(drop),  64'd0);
    chk("rst_uflow", 64'(uflow), 64'd0);

    // FIFO order: A, B, C
    cyc(1, 0, 0, mk(8'd10, 10'd1));
    chk("a_head",  64'(dout),  64'(mk(8'd10, 10'd1)));
    chk("a_valid", 64'(valid), 64'd1);
    cyc(1, 0, 0, mk(8'd20, 10'd2));
    cyc(1, 0, 0, mk(8'd30, 10'd3));
    chk("abc_count", 64'(count), 64'd3);
    chk("abc_head",  64'(dout),  64'(mk(8'd10, 10'd1)));
    cyc(0, 1, 0, '0);
    chk("pop1_data",  64'(dout),  64'(mk(8'd20, 10'd2)));
    chk("pop1_count", 64'(count), 64'd2);
    cyc(0, 1, 0, '0);
    chk("pop2_data",  64'(dout),  64'(mk(8'd30, 10'd3)));
    chk("pop2_count", 64'(count), 64'd1);
    cyc(0, 1, 0, '0);
    chk("pop3_data",  64'(dout),  64'd0);
    chk("pop3_count", 64'(count), 64'd0);
    chk("pop3_valid", 64'(valid), 64'd0);

    // Fill with scores 5, 9, 3, 7 then push score 4 while full
    cyc(1, 0, 0, mk(8'd5, 10'd11));
    cyc(1, 0, 0, mk(8'd9, 10'd12));
    cyc(1, 0, 0, mk(8'd3, 10'd13));
    cyc(1, 0, 0, mk(8'd7, 10'd14));
    chk("fill_full",  64'(full),  64'd1);
    chk("fill_count", 64'(count), 64'd4);
    cyc(1, 0, 0, mk(8'd4, 10'd15));
    chk("rep_count", 64'(count), 64'd4);
`ifdef KEYBUF_SCORE_REPLACE_EN
    chk("rep_drop", 64'(drop), 64'd0);
    // Equal to the new minimum (4) is not strictly greater: dropped
    cyc(1, 0, 0, mk(8'd4, 10'd16));
    chk("tie_drop", 64'(drop), 64'd1);
    cyc(0, 0, 0, '0);
    chk("tie_drop_end", 64'(drop), 64'd0);
    chk("rep_e0", 64'(dout), 64'(mk(8'd5, 10'd11)));
    cyc(0, 1, 0, '0);
    chk("rep_e1", 64'(dout), 64'(mk(8'd9, 10'd12)));
    cyc(0, 1, 0, '0);
    chk("rep_e2", 64'(dout), 64'(mk(8'd4, 10'd15)));
    cyc(0, 1, 0, '0);
    chk("rep_e3", 64'(dout), 64'(mk(8'd7, 10'd14)));
`else
    chk("rep_drop", 64'(drop), 64'd1);
    cyc(0, 0, 0, '0);
    chk("drop_end", 64'(drop), 64'd0);
    chk("keep_e0", 64'(dout), 64'(mk(8'd5, 10'd11)));
    cyc(0, 1, 0, '0);
    chk("keep_e1", 64'(dout), 64'(mk(8'd9, 10'd12)));
    cyc(0, 1, 0, '0);
    chk("keep_e2", 64'(dout), 64'(mk(8'd3, 10'd13)));
    cyc(0, 1, 0, '0);
    chk("keep_e3", 64'(dout), 64'(mk(8'd7, 10'd14)));
`endif
    cyc(0, 1, 0, '0);
    chk("drain_count", 64'(count), 64'd0);

    // Full queue, simultaneous push+pop of X
    cyc(1, 0, 0, mk(8'd5, 10'd21));
    cyc(1, 0, 0, mk(8'd9, 10'd22));
    cyc(1, 0, 0, mk(8'd3, 10'd23));
    cyc(1, 0, 0, mk(8'd7, 10'd24));
    cyc(1, 1, 0, mk(8'd1, 10'd25));
    chk("pp_head",  64'(dout),  64'(mk(8'd9, 10'd22)));
    chk("pp_full",  64'(full),  64'd1);
    chk("pp_count", 64'(count), 64'd4);
    chk("pp_drop",  64'(drop),  64'd0);
    cyc(0, 1, 0, '0);
    cyc(0, 1, 0, '0);
    cyc(0, 1, 0, '0);
    chk("pp_tail", 64'(dout), 64'(mk(8'd1, 10'd25)));
    cyc(0, 1, 0, '0);
    chk("pp_empty", 64'(count), 64'd0);

    // Underflow cases
    cyc(0, 1, 0, '0);
    chk("uf_pulse", 64'(uflow), 64'd1);
    chk("uf_count", 64'(count), 64'd0);
    cyc(0, 0, 0, '0);
    chk("uf_end", 64'(uflow), 64'd0);
    cyc(1, 1, 0, mk(8'd40, 10'd31));
    chk("ufpp_pulse", 64'(uflow), 64'd1);
    chk("ufpp_count", 64'(count), 64'd1);
    chk("ufpp_head",  64'(dout),  64'(mk(8'd40, 10'd31)));
    cyc(0, 0, 0, '0);
    chk("ufpp_end", 64'(uflow), 64'd0);

    // Clear beats push
    cyc(1, 0, 0, mk(8'd41, 10'd32));
    cyc(1, 0, 0, mk(8'd42, 10'd33));
    chk("pre_clr_count", 64'(count), 64'd3);
    cyc(1, 0, 1, mk(8'd43, 10'd34));
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_valid", 64'(valid), 64'd0);
    chk("clr_data",  64'(dout),  64'd0);

    // Async reset mid-stream
    cyc(1, 0, 0, mk(8'd50, 10'd41));
    cyc(1, 0, 0, mk(8'd51, 10'd42));
    chk("prerst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_data",  64'(dout),  64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, 0, mk(8'd60, 10'd43));
    chk("postrst_data",  64'(dout),  64'(mk(8'd60, 10'd43)));
    chk("postrst_count", 64'(count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
